// File: rtl/stack_param.sv
// Parametrised operand stack with push/pop/replace/dup/swap, exposing the top two entries
// together with occupancy, full/empty status and sticky overflow/underflow flags.
module stack_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d_in,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       dup,
  input  logic                       swap,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [AW-1:0]    idx_free, idx_top, idx_nos;
  logic             has_one, has_two;

  logic             we_a, we_b;
  logic [AW-1:0]    wa_a, wa_b;
  logic [WIDTH-1:0] wd_a, wd_b;

  // Array indices are truncated to AW bits; out-of-range values are never used because every
  // access is gated by the occupancy checks below.
  assign idx_free = AW'(sp_q);
  assign idx_top  = AW'(sp_q - CW'(1));
  assign idx_nos  = AW'(sp_q - CW'(2));

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == CW'(DEPTH));
  assign has_one = !empty;
  assign has_two = (sp_q >= CW'(2));

  assign count     = sp_q;
  assign tos       = has_one ? mem[idx_top] : '0;
  assign nos       = has_two ? mem[idx_nos] : '0;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_comb begin
    sp_d  = sp_q;
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    we_a  = 1'b0;
    wa_a  = '0;
    wd_a  = '0;
    we_b  = 1'b0;
    wa_b  = '0;
    wd_b  = '0;
    // Fixed priority: replace, push, pop, dup, swap; a rejection only sets its flag.
    if (push && pop) begin
      if (has_one) begin
        we_a = 1'b1;
        wa_a = idx_top;
        wd_a = d_in;
      end else begin
        unf_d = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        we_a = 1'b1;
        wa_a = idx_free;
        wd_a = d_in;
        sp_d = sp_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (pop) begin
      if (has_one) begin
        sp_d = sp_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (dup) begin
      if (!has_one) begin
        unf_d = 1'b1;
      end else if (full) begin
        ovf_d = 1'b1;
      end else begin
        we_a = 1'b1;
        wa_a = idx_free;
        wd_a = tos;
        sp_d = sp_q + CW'(1);
      end
    end else if (swap) begin
      if (has_two) begin
        we_a = 1'b1;
        wa_a = idx_top;
        wd_a = nos;
        we_b = 1'b1;
        wa_b = idx_nos;
        wd_b = tos;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is never cleared; reset only suppresses the write so no op half-completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (we_a) mem[wa_a] <= wd_a;
      if (we_b) mem[wa_b] <= wd_b;
    end
  end

endmodule

// File: tb/tb_stack_param.sv
// Self-checking bench for stack_param: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stack_param;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] d_in = '0;
  logic             push = 1'b0, pop = 1'b0, dup = 1'b0, swap = 1'b0, clr_err = 1'b0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, overflow, underflow;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  logic [WIDTH-1:0] q[$];
  bit               m_ovf = 1'b0, m_unf = 1'b0;

  stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .push     (push),
    .pop      (pop),
    .dup      (dup),
    .swap     (swap),
    .clr_err  (clr_err),
    .tos      (tos),
    .nos      (nos),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stack as a queue, top at the back.
  always @(posedge clk) begin
    bit so, su;
    int sz;
    so = 1'b0;
    su = 1'b0;
    sz = q.size();
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (push && pop) begin
        if (sz >= 1) q[sz-1] = d_in;
        else su = 1'b1;
      end else if (push) begin
        if (sz < DEPTH) q.push_back(d_in);
        else so = 1'b1;
      end else if (pop) begin
        if (sz > 0) void'(q.pop_back());
        else su = 1'b1;
      end else if (dup) begin
        if (sz == 0) su = 1'b1;
        else if (sz == DEPTH) so = 1'b1;
        else q.push_back(q[sz-1]);
      end else if (swap) begin
        if (sz >= 2) begin
          logic [WIDTH-1:0] t;
          t       = q[sz-1];
          q[sz-1] = q[sz-2];
          q[sz-2] = t;
        end else begin
          su = 1'b1;
        end
      end
      m_ovf = (m_ovf && !clr_err) || so;
      m_unf = (m_unf && !clr_err) || su;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      int sz;
      sz = q.size();
      check("count", 32'(count), 32'(sz));
      check("tos", 32'(tos), (sz > 0) ? 32'(q[sz-1]) : 32'd0);
      check("nos", 32'(nos), (sz > 1) ? 32'(q[sz-2]) : 32'd0);
      check("empty", 32'(empty), 32'(sz == 0));
      check("full", 32'(full), 32'(sz == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
    end
  end

  // Apply one cycle of requests; returns shortly after the edge with outputs updated.
  task automatic step(input bit r, input bit pu, input bit po, input bit du, input bit sw,
                      input bit ce, input logic [WIDTH-1:0] d);
    rst = r; push = pu; pop = po; dup = du; swap = sw; clr_err = ce; d_in = d;
    @(posedge clk);
    #2;
    rst = 1'b0; push = 1'b0; pop = 1'b0; dup = 1'b0; swap = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 8'h00);
    check_en = 1'b1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_tos", 32'(tos), 32'd0);
    check("rst_flags", 32'({overflow, underflow, full}), 32'd0);

    // Fill and overflow.
    step(0, 1, 0, 0, 0, 0, 8'h11);
    step(0, 1, 0, 0, 0, 0, 8'h22);
    step(0, 1, 0, 0, 0, 0, 8'h33);
    check("fill_tos", 32'(tos), 32'h33);
    check("fill_nos", 32'(nos), 32'h22);
    check("fill_count", 32'(count), 32'd3);
    step(0, 1, 0, 0, 0, 0, 8'h44);
    check("full_flag", 32'(full), 32'd1);
    check("full_tos", 32'(tos), 32'h44);
    step(0, 1, 0, 0, 0, 0, 8'h55);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_tos", 32'(tos), 32'h44);

    // Swap, dup, replace.
    step(1, 0, 0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 0, 0, 8'h11);
    step(0, 1, 0, 0, 0, 0, 8'h22);
    step(0, 0, 0, 0, 1, 0, 8'h00);
    check("swap_tos", 32'(tos), 32'h11);
    check("swap_nos", 32'(nos), 32'h22);
    step(0, 0, 0, 1, 0, 0, 8'h00);
    check("dup_count", 32'(count), 32'd3);
    check("dup_tos", 32'(tos), 32'h11);
    check("dup_nos", 32'(nos), 32'h11);
    step(0, 1, 1, 0, 0, 0, 8'h7E);
    check("repl_tos", 32'(tos), 32'h7E);
    check("repl_count", 32'(count), 32'd3);

    // Underflow on empty stack.
    step(1, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 0, 8'h00);
    check("unf_pop", 32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
    step(0, 0, 0, 0, 1, 0, 8'h00);
    step(0, 1, 1, 0, 0, 0, 8'h99);
    check("unf_tos", 32'(tos), 32'd0);
    check("unf_nos", 32'(nos), 32'd0);
    check("unf_cnt2", 32'(count), 32'd0);
    step(0, 1, 0, 0, 0, 1, 8'h5A);
    check("clr_push_unf", 32'(underflow), 32'd0);
    check("clr_push_count", 32'(count), 32'd1);

    // Swap with one entry; set beats clear.
    step(0, 0, 0, 0, 1, 0, 8'h00);
    check("swap1_unf", 32'(underflow), 32'd1);
    check("swap1_tos", 32'(tos), 32'h5A);
    step(0, 0, 0, 0, 1, 1, 8'h00);
    check("setwins_unf", 32'(underflow), 32'd1);
    step(0, 0, 0, 0, 0, 1, 8'h00);
    check("clr_unf", 32'(underflow), 32'd0);

    // Burst of push+dup+swap interrupted by reset.
    step(1, 0, 0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 0, 0, 0, 8'h01);
    step(0, 1, 0, 0, 0, 0, 8'h02);
    step(0, 1, 0, 0, 0, 0, 8'h03);
    step(0, 1, 0, 1, 1, 0, 8'hA4);
    check("burst_count", 32'(count), 32'd4);
    check("burst_tos", 32'(tos), 32'hA4);
    check("burst_nos", 32'(nos), 32'h03);
    step(0, 1, 0, 1, 1, 0, 8'hA5);
    check("burst_ovf", 32'(overflow), 32'd1);
    step(1, 1, 0, 1, 1, 0, 8'hA6);
    check("burst_rst_count", 32'(count), 32'd0);
    check("burst_rst_tos", 32'(tos), 32'd0);
    check("burst_rst_flags", 32'({overflow, underflow}), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6,
           WIDTH'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_param.md
# stack_param

Parametrised hardware operand stack for the stack-based multicycle RISC-V datapath; successor to the fixed 8-bit x 32 stack. Provides push/pop, a same-cycle replace, DUP and SWAP primitives, and exposes top-of-stack and next-on-stack together so binary ALU ops read both operands in one cycle. Adds occupancy, full/empty status and sticky overflow/underflow flags for the controller's exception path.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 32, number of entries (>=2)
- CW, $clog2(DEPTH+1), count width (derived localparam, not overridable)

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- d_in  in  WIDTH  data for push / replace
- push  in  1  push request
- pop  in  1  pop request
- dup  in  1  duplicate top-of-stack request
- swap  in  1  exchange top two entries request
- clr_err  in  1  clear sticky error flags
- tos  out  WIDTH  top entry (mem[sp-1]), 0 when empty
- nos  out  WIDTH  second entry (mem[sp-2]), 0 when count<2
- count  out  CW  current occupancy, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky: a growing op was rejected because full
- underflow  out  1  sticky: an op was rejected for lack of operands

## Operation
- State: storage array mem[0..DEPTH-1], pointer sp (=count), two flags. sp points at next free slot.
- One op per cycle, decoded by priority:
  1. push&pop: REPLACE. count>=1: mem[sp-1]<=d_in, sp unchanged. Empty: rejected, underflow set.
  2. push only: !full: mem[sp]<=d_in, sp+1. Full: rejected, overflow set.
  3. pop only: !empty: sp-1 (data not cleared). Empty: rejected, underflow set.
  4. dup (push=pop=0): count>=1 and !full: mem[sp]<=tos, sp+1. Empty: underflow (checked first). Full: overflow.
  5. swap (push=pop=dup=0): count>=2: mem[sp-1]<=nos, mem[sp-2]<=tos. Else underflow.
  6. None: hold.
- Lower-priority requests asserted alongside a higher one are ignored entirely (no flag effect).
- Rejected op: mem and sp unchanged; only the named flag is set.
- Flags: sticky until rst or clr_err. clr_err with a same-cycle rejection: flag ends set (set wins).
- rst overrides every input: sp<=0, overflow<=0, underflow<=0. mem contents are not cleared; they are unobservable because tos/nos gate on count.
- Reset mid-sequence discards stack contents logically; no partial op completes.
- Pointer arithmetic in CW bits; no wrap-around ever occurs because bounds are checked before update.

## Timing
- All outputs are combinational functions of registered state (sp, mem, flags); no combinational path from request inputs or d_in to any output.
- Latency: an op sampled at edge N is visible on tos/nos/count/empty/full/flags after edge N.
- Back-to-back ops every cycle are supported; no handshake, no busy state.
- Reset values (after the rst edge): tos=0, nos=0, count=0, empty=1, full=0, overflow=0, underflow=0.
- mem is a synchronous-write, asynchronous-read array; two write ports are needed only for swap (same cycle, distinct addresses).

## Test plan
All with WIDTH=8, DEPTH=4.
- Reset then push 0x11,0x22,0x33 on consecutive cycles -> tos=0x33, nos=0x22, count=3, empty=0, full=0.
- From count=3, push 0x44 then push 0x55 -> after first: full=1, tos=0x44; after second: overflow=1, count=4, tos=0x44 unchanged.
- Stack {0x11,0x22} (0x22 top): swap -> tos=0x11, nos=0x22; then dup -> count=3, tos=0x11, nos=0x11; then push&pop with d_in=0x7E -> tos=0x7E, count=3.
- Empty stack: pop, then swap, then push&pop -> underflow=1 after first, count stays 0, tos=0, nos=0; push+clr_err same cycle clears flag and pushes (count=1).
- count=1: swap -> underflow=1, tos unchanged; clr_err together with another swap -> underflow stays 1; clr_err alone next cycle -> 0.
- count=3 with push, dup and swap all asserted every cycle, rst asserted mid-burst -> pushes proceed (dup/swap ignored) until rst edge; after it count=0, tos=0, flags=0 regardless of requests that cycle.
